// File: rtl/sd_spi_arbiter_if.sv
// Bus bundle between the two SD-SPI requesters, the arbiter and the shared
// block-read controller.
interface sd_spi_arbiter_if;
  logic        req_a, req_b;
  logic        r_block_a, r_block_b;
  logic        r_byte_a, r_byte_b;
  logic        r_multi_block_a, r_multi_block_b;
  logic [31:0] addr_a, addr_b;
  logic        busy_a, busy_b;
  logic        err_a, err_b;
  logic [7:0]  data_out;
  logic [1:0]  grant;
  logic        spi_r_block, spi_r_byte, spi_r_multi_block;
  logic [31:0] spi_block_addr;
  logic        spi_busy;
  logic [7:0]  spi_data_out;
  logic        spi_err;
  logic        spi_rst;

  modport slave (
    input  req_a, req_b, r_block_a, r_block_b, r_byte_a, r_byte_b,
           r_multi_block_a, r_multi_block_b, addr_a, addr_b,
           spi_busy, spi_data_out, spi_err,
    output busy_a, busy_b, err_a, err_b, data_out, grant,
           spi_r_block, spi_r_byte, spi_r_multi_block, spi_block_addr, spi_rst
  );

  modport master (
    output req_a, req_b, r_block_a, r_block_b, r_byte_a, r_byte_b,
           r_multi_block_a, r_multi_block_b, addr_a, addr_b,
           spi_busy, spi_data_out, spi_err,
    input  busy_a, busy_b, err_a, err_b, data_out, grant,
           spi_r_block, spi_r_byte, spi_r_multi_block, spi_block_addr, spi_rst
  );
endinterface

// File: rtl/sd_spi_arbiter.sv
// Round-robin arbiter sharing one SD-SPI block-read controller between ports A and B.
// Define SD_SPI_ARB_TIMEOUT_EN to add the hung-transaction watchdog (TIMEOUT state, spi_rst pulse).
module sd_spi_arbiter
`ifdef SD_SPI_ARB_TIMEOUT_EN
  #(parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF)
`endif
(
  input logic             clk,
  input logic             reset_n,
  sd_spi_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT_A,
    GRANT_B,
    RELEASE
`ifdef SD_SPI_ARB_TIMEOUT_EN
    , TIMEOUT
`endif
  } state_t;

  state_t state, next_state;
  logic   last_owner_b;

`ifdef SD_SPI_ARB_TIMEOUT_EN
  logic [23:0] wd_cnt;
  logic        wd_err;
  logic        wd_fire;
`endif

  assign bus.data_out = bus.spi_data_out;

  always_comb begin
    next_state            = state;
    bus.grant             = 2'b00;
    bus.busy_a            = 1'b1;
    bus.busy_b            = 1'b1;
    bus.err_a             = 1'b0;
    bus.err_b             = 1'b0;
    bus.spi_r_block       = 1'b0;
    bus.spi_r_byte        = 1'b0;
    bus.spi_r_multi_block = 1'b0;
    bus.spi_block_addr    = '0;
    bus.spi_rst           = 1'b0;
`ifdef SD_SPI_ARB_TIMEOUT_EN
    wd_fire               = 1'b0;
`endif
    case (state)
      IDLE: begin
        // On a tie, A wins unless A was the last owner.
        if (bus.req_a && (!bus.req_b || last_owner_b)) next_state = GRANT_A;
        else if (bus.req_b)                            next_state = GRANT_B;
      end
      GRANT_A: begin
        bus.grant          = 2'b01;
        bus.busy_a         = bus.spi_busy;
        bus.err_a          = bus.spi_err;
        bus.spi_block_addr = bus.addr_a;
        if (bus.req_a) begin
          bus.spi_r_block       = bus.r_block_a;
          bus.spi_r_byte        = bus.r_byte_a;
          bus.spi_r_multi_block = bus.r_multi_block_a;
        end
`ifdef SD_SPI_ARB_TIMEOUT_EN
        if (wd_err) begin
          bus.err_a             = bus.spi_err | bus.req_a;
          bus.spi_r_block       = 1'b0;
          bus.spi_r_byte        = 1'b0;
          bus.spi_r_multi_block = 1'b0;
        end
        wd_fire = !wd_err && bus.spi_busy && (wd_cnt == TIMEOUT_CYCLES - 24'd2);
        if (wd_fire) next_state = TIMEOUT;
`endif
        if (!bus.req_a && !bus.spi_busy) next_state = RELEASE;
      end
      GRANT_B: begin
        bus.grant          = 2'b10;
        bus.busy_b         = bus.spi_busy;
        bus.err_b          = bus.spi_err;
        bus.spi_block_addr = bus.addr_b;
        if (bus.req_b) begin
          bus.spi_r_block       = bus.r_block_b;
          bus.spi_r_byte        = bus.r_byte_b;
          bus.spi_r_multi_block = bus.r_multi_block_b;
        end
`ifdef SD_SPI_ARB_TIMEOUT_EN
        if (wd_err) begin
          bus.err_b             = bus.spi_err | bus.req_b;
          bus.spi_r_block       = 1'b0;
          bus.spi_r_byte        = 1'b0;
          bus.spi_r_multi_block = 1'b0;
        end
        wd_fire = !wd_err && bus.spi_busy && (wd_cnt == TIMEOUT_CYCLES - 24'd2);
        if (wd_fire) next_state = TIMEOUT;
`endif
        if (!bus.req_b && !bus.spi_busy) next_state = RELEASE;
      end
      RELEASE: next_state = IDLE;
`ifdef SD_SPI_ARB_TIMEOUT_EN
      // One-cycle controller reset; the owner keeps the grant with error latched.
      TIMEOUT: begin
        bus.spi_rst = 1'b1;
        if (last_owner_b) begin
          bus.grant          = 2'b10;
          bus.busy_b         = bus.spi_busy;
          bus.err_b          = 1'b1;
          bus.spi_block_addr = bus.addr_b;
          next_state         = GRANT_B;
        end else begin
          bus.grant          = 2'b01;
          bus.busy_a         = bus.spi_busy;
          bus.err_a          = 1'b1;
          bus.spi_block_addr = bus.addr_a;
          next_state         = GRANT_A;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_owner_b <= 1'b1;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == GRANT_A) last_owner_b <= 1'b0;
      if (state == IDLE && next_state == GRANT_B) last_owner_b <= 1'b1;
    end
  end

`ifdef SD_SPI_ARB_TIMEOUT_EN
  // The watchdog arms once per transaction; after firing it stays quiet until release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      if ((state == GRANT_A || state == GRANT_B) && bus.spi_busy && !wd_err && !wd_fire)
        wd_cnt <= wd_cnt + 24'd1;
      else
        wd_cnt <= '0;
      if (state == TIMEOUT)                         wd_err <= 1'b1;
      else if (state == RELEASE || state == IDLE)   wd_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Scenario-driven bench for sd_spi_arbiter; expected outputs are queued per cycle and
// compared at the falling edge. Timeout scenario runs when SD_SPI_ARB_TIMEOUT_EN is defined.
module tb_sd_spi_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sd_spi_arbiter_if bus();

`ifdef SD_SPI_ARB_TIMEOUT_EN
  sd_spi_arbiter #(.TIMEOUT_CYCLES(24'd16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`else
  sd_spi_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

  typedef struct packed {
    logic [1:0]  grant;
    logic        busy_a, busy_b, err_a, err_b, blk, byt, mul, rst;
    logic [31:0] addr;
    logic [7:0]  data;
  } obs_t;

  typedef struct packed {
    logic req_a, req_b, blk_a, byt_a, mul_a, blk_b, byt_b, mul_b, busy, err;
  } stim_t;

  localparam logic [31:0] ADDR_A = 32'h0000_0800;
  localparam logic [31:0] ADDR_B = 32'h00AB_CD00;

  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];
  obs_t got, exp;
  logic [7:0] cur_data;

  function automatic stim_t st(input logic ra, rb, ba, ya, ma, bb, yb, mb, busy, err);
    stim_t s;
    s = {ra, rb, ba, ya, ma, bb, yb, mb, busy, err};
    return s;
  endfunction

  function automatic obs_t mk(input logic [1:0] g, input logic ba, bb, ea, eb, blk, byt, mul, rst,
                              input logic [31:0] addr);
    obs_t o;
    o = {g, ba, bb, ea, eb, blk, byt, mul, rst, addr, cur_data};
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.grant  = bus.grant;
    o.busy_a = bus.busy_a;
    o.busy_b = bus.busy_b;
    o.err_a  = bus.err_a;
    o.err_b  = bus.err_b;
    o.blk    = bus.spi_r_block;
    o.byt    = bus.spi_r_byte;
    o.mul    = bus.spi_r_multi_block;
    o.rst    = bus.spi_rst;
    o.addr   = bus.spi_block_addr;
    o.data   = bus.data_out;
    return o;
  endfunction

  task automatic drive(input stim_t s);
    bus.req_a           = s.req_a;
    bus.req_b           = s.req_b;
    bus.r_block_a       = s.blk_a;
    bus.r_byte_a        = s.byt_a;
    bus.r_multi_block_a = s.mul_a;
    bus.r_block_b       = s.blk_b;
    bus.r_byte_b        = s.byt_b;
    bus.r_multi_block_b = s.mul_b;
    bus.spi_busy        = s.busy;
    bus.spi_err         = s.err;
  endtask

  task automatic set_data(input logic [7:0] d);
    cur_data         = d;
    bus.spi_data_out = d;
  endtask

  task automatic test_reset();
    bus.addr_a = ADDR_A;
    bus.addr_b = ADDR_B;
    set_data(8'h5A);
    drive('0);
    sb.push_back(mk(2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0));
    @(negedge clk);
    got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_hold: got %h expected %h", got, exp); end
    @(posedge clk); #1 reset_n = 1'b1;
    sb.push_back(mk(2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0));
    @(negedge clk);
    got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_idle: got %h expected %h", got, exp); end
  endtask

  task automatic test_grant_a();
    stim_t s[6];
    obs_t  e[6];
    set_data(8'hA5);
    s = '{st(1,0,1,0,0,0,0,0,0,0), st(1,0,1,0,0,0,0,0,1,0), st(1,0,0,1,0,0,0,0,0,0),
          st(0,0,0,0,0,0,0,0,0,0), st(0,0,0,0,0,0,0,0,0,0), st(0,0,0,0,0,0,0,0,0,0)};
    e = '{mk(2'b00,1,1,0,0,0,0,0,0,32'h0), mk(2'b01,1,1,0,0,1,0,0,0,ADDR_A),
          mk(2'b01,0,1,0,0,0,1,0,0,ADDR_A), mk(2'b01,0,1,0,0,0,0,0,0,ADDR_A),
          mk(2'b00,1,1,0,0,0,0,0,0,32'h0), mk(2'b00,1,1,0,0,0,0,0,0,32'h0)};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 drive(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL grant_a[%0d]: got %h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_tie_round_robin();
    stim_t s[6];
    obs_t  e[6];
    @(posedge clk); #1 reset_n = 1'b0; drive('0);
    @(posedge clk); #1 reset_n = 1'b1;
    set_data(8'h3C);
    s = '{st(1,1,0,0,0,0,0,0,0,0), st(1,1,0,0,0,0,0,0,0,0), st(0,1,0,0,0,0,0,0,0,0),
          st(0,1,0,0,0,0,0,0,0,0), st(0,1,0,0,0,0,0,0,0,0), st(0,1,0,0,0,0,0,0,0,0)};
    e = '{mk(2'b00,1,1,0,0,0,0,0,0,32'h0), mk(2'b01,0,1,0,0,0,0,0,0,ADDR_A),
          mk(2'b01,0,1,0,0,0,0,0,0,ADDR_A), mk(2'b00,1,1,0,0,0,0,0,0,32'h0),
          mk(2'b00,1,1,0,0,0,0,0,0,32'h0), mk(2'b10,1,0,0,0,0,0,0,0,ADDR_B)};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 drive(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL tie_rr[%0d]: got %h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_busy_hold();
    stim_t s;
    obs_t  e;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        s = st(0,1,0,0,0,0,0,1,1,0); e = mk(2'b10,1,1,0,0,0,0,1,0,ADDR_B);
      end else if (i <= 5) begin
        s = st(0,0,0,0,0,0,0,1,1,0); e = mk(2'b10,1,1,0,0,0,0,0,0,ADDR_B);
      end else if (i == 6) begin
        s = st(0,0,0,0,0,0,0,1,0,0); e = mk(2'b10,1,0,0,0,0,0,0,0,ADDR_B);
      end else begin
        s = '0;                      e = mk(2'b00,1,1,0,0,0,0,0,0,32'h0);
      end
      @(posedge clk); #1 drive(s); sb.push_back(e);
      @(negedge clk);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL busy_hold[%0d]: got %h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_err_owner();
    stim_t s[10];
    obs_t  e[10];
    set_data(8'hC3);
    s = '{st(0,1,0,0,0,0,0,0,0,0), st(0,1,1,0,0,0,0,0,0,1), st(0,1,0,0,0,1,0,0,0,1),
          st(1,0,0,0,0,0,0,0,0,0), st(1,0,0,0,0,0,0,0,0,0), st(1,0,0,0,0,0,0,0,0,0),
          st(1,0,0,0,0,0,0,0,0,0), st(0,0,0,0,0,0,0,0,0,0), st(0,0,0,0,0,0,0,0,0,0),
          st(0,0,0,0,0,0,0,0,0,0)};
    e = '{mk(2'b00,1,1,0,0,0,0,0,0,32'h0), mk(2'b10,1,0,0,1,0,0,0,0,ADDR_B),
          mk(2'b10,1,0,0,1,1,0,0,0,ADDR_B), mk(2'b10,1,0,0,0,0,0,0,0,ADDR_B),
          mk(2'b00,1,1,0,0,0,0,0,0,32'h0), mk(2'b00,1,1,0,0,0,0,0,0,32'h0),
          mk(2'b01,0,1,0,0,0,0,0,0,ADDR_A), mk(2'b01,0,1,0,0,0,0,0,0,ADDR_A),
          mk(2'b00,1,1,0,0,0,0,0,0,32'h0), mk(2'b00,1,1,0,0,0,0,0,0,32'h0)};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 drive(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL err_owner[%0d]: got %h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_async_reset();
    stim_t s[2];
    obs_t  e[2];
    set_data(8'h96);
    s = '{st(1,0,0,0,0,0,0,0,0,0), st(1,0,1,0,0,0,0,0,0,0)};
    e = '{mk(2'b00,1,1,0,0,0,0,0,0,32'h0), mk(2'b01,0,1,0,0,1,0,0,0,ADDR_A)};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1 drive(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL async_pre[%0d]: got %h expected %h", i, got, exp); end
    end
    #2 reset_n = 1'b0;
    sb.push_back(mk(2'b00,1,1,0,0,0,0,0,0,32'h0));
    #1;
    got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL async_abort: got %h expected %h", got, exp); end
    drive('0);
    @(posedge clk); #1 reset_n = 1'b1;
    sb.push_back(mk(2'b00,1,1,0,0,0,0,0,0,32'h0));
    @(negedge clk);
    got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL async_after: got %h expected %h", got, exp); end
  endtask

`ifdef SD_SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    stim_t s;
    obs_t  e;
    set_data(8'h0F);
    for (int k = 0; k < 24; k++) begin
      if (k == 0) begin
        s = st(1,0,0,0,0,0,0,0,1,0); e = mk(2'b00,1,1,0,0,0,0,0,0,32'h0);
      end else if (k <= 16) begin
        s = st(1,0,0,0,0,0,0,0,1,0);
        e = mk(2'b01,1,1,(k == 16),0,0,0,0,(k == 16),ADDR_A);
      end else if (k <= 19) begin
        s = st(1,0,1,0,0,0,0,0,1,0); e = mk(2'b01,1,1,1,0,0,0,0,0,ADDR_A);
      end else if (k == 20) begin
        s = st(0,0,0,0,0,0,0,0,1,0); e = mk(2'b01,1,1,0,0,0,0,0,0,ADDR_A);
      end else if (k == 21) begin
        s = '0;                      e = mk(2'b01,0,1,0,0,0,0,0,0,ADDR_A);
      end else begin
        s = '0;                      e = mk(2'b00,1,1,0,0,0,0,0,0,32'h0);
      end
      @(posedge clk); #1 drive(s); sb.push_back(e);
      @(negedge clk);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL timeout[%0d]: got %h expected %h", k, got, exp); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_grant_a();
    test_tie_round_robin();
    test_busy_hold();
    test_err_owner();
    test_async_reset();
`ifdef SD_SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
